m_ucode_seq: RTL and testbench



---
 rtl/m_ucode_seq_pkg.sv | 31 +++
 rtl/m_ucode_seq_waitctr.sv | 39 +++
 rtl/m_ucode_seq.sv | 184 ++++++++++++++++++
 tb/tb_m_ucode_seq.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_ucode_seq_pkg.sv
// Shared encodings for the microcode sequencer: control-word field positions,
// sequencing types and FSM states.
package ucode_pkg;

    localparam int NXT_LSB  = 0;
    localparam int NXT_MSB  = 7;
    localparam int STYP_LSB = 8;
    localparam int STYP_MSB = 10;

    typedef enum logic [2:0] {
        STYP_GOTO     = 3'd0,
        STYP_DISPATCH = 3'd1,
        STYP_COND     = 3'd2,
        STYP_WAITMEM  = 3'd3,
        STYP_LOOP     = 3'd4,
        STYP_FETCH    = 3'd5,
        STYP_TRAP     = 3'd6,
        STYP_ILL      = 3'd7
    } styp_e;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        LOOP = 2'd2
    } seq_state_e;

    function automatic logic [7:0] next_index(input logic [7:0] idx);
        return idx + 8'd1;
    endfunction

endpackage

// File: rtl/m_ucode_seq_waitctr.sv
// Memory-wait stall counter: counts consecutive stall cycles (saturating) and
// flags the cycle in which the stall budget runs out.
module m_ucode_waitctr #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic timeout
);

    // A limit of zero never times out; keep the compare value legal anyway.
    localparam bit          LIMIT_EN = (WAIT_LIMIT != 0);
    localparam int unsigned LIMIT_M1 = (WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1;

    logic [7:0] wcnt_q;
    logic [7:0] wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (clr) begin
            wcnt_d = '0;
        end else if (inc && (wcnt_q != 8'hFF)) begin
            wcnt_d = wcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign timeout = LIMIT_EN && (32'(wcnt_q) == LIMIT_M1);

endmodule

// File: rtl/m_ucode_seq.sv
// Microcode sequencer: selects the next control-ROM index every cycle.
// Interrupt entry on FETCH words is added when UCODE_SEQ_IRQ_EN is defined.
module m_ucode_seq
    import ucode_pkg::*;
#(
    parameter logic [7:0]  START_ADDR    = 8'h00,
    parameter logic [7:0]  DISPATCH_BASE = 8'h80,
    parameter logic [7:0]  TRAP_ADDR     = 8'hF0,
    parameter logic [7:0]  IRQ_ADDR      = 8'hE0,
    parameter int unsigned WAIT_LIMIT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] d,
    input  logic [4:0]  opcode,
    input  logic        cond,
    input  logic [4:0]  shamt,
    input  logic        mem_ack,
`ifdef UCODE_SEQ_IRQ_EN
    input  logic        irq,
    output logic        irq_taken,
`endif
    output logic [7:0]  minx,
    output logic        progress_ucode,
    output logic [7:0]  upc,
    output logic        seq_trap,
    output logic        mem_timeout
);

    seq_state_e state_q;
    logic [7:0] upc_q;
    logic [4:0] cnt_q;
    logic       seq_trap_q;
    logic       mem_timeout_q;

    logic [7:0] nxt;
    logic [7:0] upc_inc;
    styp_e      styp;
    logic       trap_d;
    logic       timeout_d;
    logic       wait_stall;
    logic       wait_timeout;
    logic       loop_enter;
    logic       unused_d;

`ifdef UCODE_SEQ_IRQ_EN
    logic irq_d;
    logic irq_taken_q;
`else
    logic [7:0] unused_irq_addr;
    assign unused_irq_addr = IRQ_ADDR;
`endif

    assign nxt      = d[NXT_MSB:NXT_LSB];
    assign styp     = styp_e'(d[STYP_MSB:STYP_LSB]);
    assign upc_inc  = next_index(upc_q);
    assign unused_d = ^d[47:STYP_MSB+1];

    m_ucode_waitctr #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_waitctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (wait_stall),
        .clr     (~wait_stall),
        .timeout (wait_timeout)
    );

    // Next-index mux; a stalled cycle keeps minx on the current word.
    always_comb begin
        minx           = upc_q;
        progress_ucode = 1'b0;
        trap_d         = 1'b0;
        timeout_d      = 1'b0;
        wait_stall     = 1'b0;
        loop_enter     = 1'b0;
`ifdef UCODE_SEQ_IRQ_EN
        irq_d          = 1'b0;
`endif
        case (state_q)
            BOOT: begin
                minx           = START_ADDR;
                progress_ucode = 1'b1;
            end
            LOOP: begin
                if (cnt_q == 5'd0) begin
                    minx           = upc_inc;
                    progress_ucode = 1'b1;
                end
            end
            default: begin
                progress_ucode = 1'b1;
                case (styp)
                    STYP_GOTO:     minx = nxt;
                    STYP_DISPATCH: minx = DISPATCH_BASE | {3'b000, opcode};
                    STYP_COND:     minx = cond ? nxt : upc_inc;
                    STYP_WAITMEM: begin
                        // An acknowledge in the limit cycle still wins over the trap.
                        if (mem_ack) begin
                            minx = nxt;
                        end else if (wait_timeout) begin
                            minx      = TRAP_ADDR;
                            trap_d    = 1'b1;
                            timeout_d = 1'b1;
                        end else begin
                            progress_ucode = 1'b0;
                            wait_stall     = 1'b1;
                        end
                    end
                    STYP_LOOP: begin
                        if (shamt == 5'd0) begin
                            minx = upc_inc;
                        end else begin
                            progress_ucode = 1'b0;
                            loop_enter     = 1'b1;
                        end
                    end
                    STYP_FETCH: begin
                        minx = nxt;
`ifdef UCODE_SEQ_IRQ_EN
                        if (irq) begin
                            minx  = IRQ_ADDR;
                            irq_d = 1'b1;
                        end
`endif
                    end
                    default: begin
                        minx   = TRAP_ADDR;
                        trap_d = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // The entry cycle is the first body cycle, so LOOP starts at shamt-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            upc_q         <= START_ADDR;
            cnt_q         <= '0;
            seq_trap_q    <= 1'b0;
            mem_timeout_q <= 1'b0;
`ifdef UCODE_SEQ_IRQ_EN
            irq_taken_q   <= 1'b0;
`endif
        end else begin
            seq_trap_q <= trap_d;
`ifdef UCODE_SEQ_IRQ_EN
            irq_taken_q <= irq_d;
`endif
            if (timeout_d) begin
                mem_timeout_q <= 1'b1;
            end
            if (progress_ucode) begin
                upc_q <= minx;
            end
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (loop_enter) begin
                        state_q <= LOOP;
                        cnt_q   <= shamt - 5'd1;
                    end
                end
                default: begin
                    if (cnt_q == 5'd0) begin
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
            endcase
        end
    end

    assign upc         = upc_q;
    assign seq_trap    = seq_trap_q;
    assign mem_timeout = mem_timeout_q;
`ifdef UCODE_SEQ_IRQ_EN
    assign irq_taken   = irq_taken_q;
`endif

endmodule

// File: tb/tb_m_ucode_seq.sv
// Bench for m_ucode_seq: directed scenarios plus a randomized run, checked
// against a cycle-level model of the sequencing rules (WAIT_LIMIT set to 4).
`timescale 1ns/1ps
module tb_m_ucode_seq;

    localparam int LIMIT = 4;
    localparam logic [2:0] S_GOTO = 3'd0, S_DISP = 3'd1, S_COND = 3'd2, S_WAIT = 3'd3;
    localparam logic [2:0] S_LOOP = 3'd4, S_FETCH = 3'd5;

    logic        clk;
    logic        rst_n;
    logic [47:0] d;
    logic [4:0]  opcode;
    logic        cond;
    logic [4:0]  shamt;
    logic        mem_ack;
    logic        irq_s;
    logic [7:0]  minx;
    logic        progress_ucode;
    logic [7:0]  upc;
    logic        seq_trap;
    logic        mem_timeout;
`ifdef UCODE_SEQ_IRQ_EN
    logic        irq_taken;
    bit          m_irq, nx_irq;
`endif

    // Reference model: booted flag, loop progress as body cycles done/target.
    bit         m_booted, m_in_loop, m_timeout, m_trap;
    logic [7:0] m_upc;
    int         m_done, m_target, m_waited;
    bit         nx_booted, nx_in_loop, nx_timeout, nx_trap;
    int         nx_done, nx_target, nx_waited;
    logic [7:0] exp_minx;
    logic       exp_prog;
    bit         exp_mv;

    int n_checks;
    int n_pass;

    m_ucode_seq #(
        .WAIT_LIMIT (LIMIT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .d              (d),
        .opcode         (opcode),
        .cond           (cond),
        .shamt          (shamt),
        .mem_ack        (mem_ack),
`ifdef UCODE_SEQ_IRQ_EN
        .irq            (irq_s),
        .irq_taken      (irq_taken),
`endif
        .minx           (minx),
        .progress_ucode (progress_ucode),
        .upc            (upc),
        .seq_trap       (seq_trap),
        .mem_timeout    (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] mkw(input logic [2:0] s, input logic [7:0] n);
        logic [47:0] w;
        w[47:16] = $urandom;
        w[15:11] = 5'($urandom);
        w[10:8]  = s;
        w[7:0]   = n;
        return w;
    endfunction

    task automatic model_eval();
        logic [7:0] nxt;
        logic [2:0] st;
        nxt = d[7:0];
        st  = d[10:8];
        nx_booted = m_booted; nx_in_loop = m_in_loop; nx_timeout = m_timeout;
        nx_done = m_done; nx_target = m_target; nx_waited = m_waited;
        nx_trap = 1'b0;
`ifdef UCODE_SEQ_IRQ_EN
        nx_irq = 1'b0;
`endif
        exp_minx = m_upc;
        exp_prog = 1'b1;
        exp_mv   = 1'b1;
        if (!m_booted) begin
            exp_minx  = 8'h00;
            nx_booted = 1'b1;
        end else if (m_in_loop) begin
            if (m_done == m_target) begin
                exp_minx   = m_upc + 8'd1;
                nx_in_loop = 1'b0;
            end else begin
                exp_prog = 1'b0;
                exp_mv   = 1'b0;
                nx_done  = m_done + 1;
            end
        end else begin
            case (st)
                S_GOTO: exp_minx = nxt;
                S_DISP: exp_minx = 8'h80 + {3'b000, opcode};
                S_COND: exp_minx = cond ? nxt : m_upc + 8'd1;
                S_WAIT: begin
                    if (mem_ack) begin
                        exp_minx  = nxt;
                        nx_waited = 0;
                    end else if (m_waited + 1 == LIMIT) begin
                        exp_minx   = 8'hF0;
                        nx_trap    = 1'b1;
                        nx_timeout = 1'b1;
                        nx_waited  = 0;
                    end else begin
                        exp_prog  = 1'b0;
                        nx_waited = m_waited + 1;
                    end
                end
                S_LOOP: begin
                    if (shamt == 5'd0) begin
                        exp_minx = m_upc + 8'd1;
                    end else begin
                        exp_prog   = 1'b0;
                        exp_mv     = 1'b0;
                        nx_in_loop = 1'b1;
                        nx_done    = 1;
                        nx_target  = int'(shamt);
                    end
                end
                S_FETCH: begin
                    exp_minx = nxt;
`ifdef UCODE_SEQ_IRQ_EN
                    if (irq_s) begin
                        exp_minx = 8'hE0;
                        nx_irq   = 1'b1;
                    end
`endif
                end
                default: begin
                    exp_minx = 8'hF0;
                    nx_trap  = 1'b1;
                end
            endcase
        end
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            m_booted = 1'b0; m_upc = 8'h00; m_in_loop = 1'b0; m_done = 0; m_target = 0;
            m_waited = 0; m_timeout = 1'b0; m_trap = 1'b0;
`ifdef UCODE_SEQ_IRQ_EN
            m_irq = 1'b0;
`endif
        end else begin
            if (exp_prog) m_upc = exp_minx;
            m_booted = nx_booted; m_in_loop = nx_in_loop; m_timeout = nx_timeout;
            m_done = nx_done; m_target = nx_target; m_waited = nx_waited; m_trap = nx_trap;
`ifdef UCODE_SEQ_IRQ_EN
            m_irq = nx_irq;
`endif
        end
    endtask

    task automatic drive(input logic [47:0] dv, input logic [4:0] op, input logic cv,
                         input logic [4:0] sh, input logic ak, input logic iq);
        @(negedge clk);
        d = dv; opcode = op; cond = cv; shamt = sh; mem_ack = ak; irq_s = iq;
        model_eval();
        #1;
    endtask

    task automatic drive_w(input logic [47:0] dv);
        drive(dv, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            drive(mkw(3'($urandom), 8'($urandom)), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            advance();
        end
        n_checks++;
        if (upc !== 8'h00) $display("[TB] FAIL reset_upc: got %h expected 00", upc);
        else n_pass++;
        n_checks++;
        if (seq_trap !== 1'b0 || mem_timeout !== 1'b0)
            $display("[TB] FAIL reset_flags: trap=%b timeout=%b expected 0/0", seq_trap, mem_timeout);
        else n_pass++;
        rst_n = 1'b1;
        drive(mkw(3'($urandom), 8'($urandom)), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'b0);
        n_checks++;
        if (minx !== 8'h00 || progress_ucode !== 1'b1)
            $display("[TB] FAIL boot_minx: minx=%h prog=%b expected 00/1", minx, progress_ucode);
        else n_pass++;
        advance();
        n_checks++;
        if (upc !== 8'h00 || seq_trap !== 1'b0)
            $display("[TB] FAIL boot_upc: upc=%h trap=%b expected 00/0", upc, seq_trap);
        else n_pass++;
    endtask

    task automatic test_dispatch_cond();
        drive(mkw(S_DISP, 8'($urandom)), 5'h0C, 1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if (minx !== 8'h8C || progress_ucode !== 1'b1)
            $display("[TB] FAIL dispatch: minx=%h prog=%b expected 8c/1", minx, progress_ucode);
        else n_pass++;
        advance();
        drive_w(mkw(S_GOTO, 8'h21));
        advance();
        n_checks++;
        if (upc !== 8'h21) $display("[TB] FAIL goto_upc: got %h expected 21", upc);
        else n_pass++;
        drive(mkw(S_COND, 8'h40), 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if (minx !== 8'h40) $display("[TB] FAIL cond_taken: got %h expected 40", minx);
        else n_pass++;
        cond = 1'b0;
        model_eval();
        #1;
        n_checks++;
        if (minx !== 8'h22) $display("[TB] FAIL cond_fall: got %h expected 22", minx);
        else n_pass++;
        advance();
        drive_w(mkw(S_GOTO, 8'hFF));
        advance();
        drive(mkw(S_COND, 8'h40), 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        n_checks++;
        if (minx !== 8'h00 || progress_ucode !== 1'b1)
            $display("[TB] FAIL cond_wrap: minx=%h prog=%b expected 00/1", minx, progress_ucode);
        else n_pass++;
        advance();
        n_checks++;
        if (upc !== 8'h00) $display("[TB] FAIL wrap_upc: got %h expected 00", upc);
        else n_pass++;
    endtask

    task automatic test_waitmem();
        logic [47:0] w;
        logic [7:0]  stay;
        drive_w(mkw(S_GOTO, 8'h30));
        advance();
        w = mkw(S_WAIT, 8'h55);
        // The second round only stalls a full 3 cycles if the counter was cleared.
        for (int r = 0; r < 2; r++) begin
            stay = (r == 0) ? 8'h30 : 8'h55;
            for (int i = 0; i < 3; i++) begin
                drive(w, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
                n_checks++;
                if (progress_ucode !== 1'b0 || minx !== stay)
                    $display("[TB] FAIL wait_stall: prog=%b minx=%h expected 0/%h", progress_ucode, minx, stay);
                else n_pass++;
                advance();
            end
            drive(w, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
            n_checks++;
            if (minx !== 8'h55 || progress_ucode !== 1'b1)
                $display("[TB] FAIL wait_ack: minx=%h prog=%b expected 55/1", minx, progress_ucode);
            else n_pass++;
            advance();
            n_checks++;
            if (upc !== 8'h55 || seq_trap !== 1'b0)
                $display("[TB] FAIL wait_done: upc=%h trap=%b expected 55/0", upc, seq_trap);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        logic [47:0] w;
        w = mkw(S_WAIT, 8'h66);
        for (int i = 0; i < 3; i++) begin
            drive(w, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            n_checks++;
            if (progress_ucode !== 1'b0) $display("[TB] FAIL to_stall: prog=%b expected 0", progress_ucode);
            else n_pass++;
            advance();
        end
        drive(w, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if (minx !== 8'hF0 || progress_ucode !== 1'b1)
            $display("[TB] FAIL to_trap: minx=%h prog=%b expected f0/1", minx, progress_ucode);
        else n_pass++;
        advance();
        n_checks++;
        if (seq_trap !== 1'b1 || mem_timeout !== 1'b1 || upc !== 8'hF0)
            $display("[TB] FAIL to_flags: trap=%b timeout=%b upc=%h expected 1/1/f0", seq_trap, mem_timeout, upc);
        else n_pass++;
        drive_w(mkw(S_GOTO, 8'h10));
        advance();
        n_checks++;
        if (seq_trap !== 1'b0 || mem_timeout !== 1'b1)
            $display("[TB] FAIL to_sticky: trap=%b timeout=%b expected 0/1", seq_trap, mem_timeout);
        else n_pass++;
        w = mkw(S_WAIT, 8'h77);
        for (int i = 0; i < 3; i++) begin
            drive(w, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            advance();
        end
        drive(w, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        n_checks++;
        if (minx !== 8'h77 || progress_ucode !== 1'b1)
            $display("[TB] FAIL to_late_ack: minx=%h prog=%b expected 77/1", minx, progress_ucode);
        else n_pass++;
        advance();
        n_checks++;
        if (seq_trap !== 1'b0 || upc !== 8'h77)
            $display("[TB] FAIL to_ack_notrap: trap=%b upc=%h expected 0/77", seq_trap, upc);
        else n_pass++;
    endtask

    task automatic test_loop();
        logic [47:0] w;
        int stalls;
        drive_w(mkw(S_GOTO, 8'h40));
        advance();
        w = mkw(S_LOOP, 8'($urandom));
        stalls = 0;
        drive(w, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0);
        while (progress_ucode === 1'b0 && stalls < 20) begin
            stalls++;
            advance();
            drive(w, 5'd0, 1'b0, 5'($urandom), 1'b0, 1'b0);
        end
        n_checks++;
        if (stalls != 3) $display("[TB] FAIL loop_len: stalled %0d cycles expected 3", stalls);
        else n_pass++;
        n_checks++;
        if (minx !== 8'h41) $display("[TB] FAIL loop_exit: minx=%h expected 41", minx);
        else n_pass++;
        advance();
        drive(w, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if (minx !== 8'h42 || progress_ucode !== 1'b1)
            $display("[TB] FAIL loop_zero: minx=%h prog=%b expected 42/1", minx, progress_ucode);
        else n_pass++;
        advance();
        drive(w, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0);
        advance();
        drive(w, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0);
        advance();
        rst_n = 1'b0;
        drive(w, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0);
        advance();
        rst_n = 1'b1;
        drive(w, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0);
        n_checks++;
        if (minx !== 8'h00 || progress_ucode !== 1'b1)
            $display("[TB] FAIL loop_reset: minx=%h prog=%b expected 00/1", minx, progress_ucode);
        else n_pass++;
        advance();
        drive_w(mkw(S_GOTO, 8'h12));
        n_checks++;
        if (minx !== 8'h12 || progress_ucode !== 1'b1)
            $display("[TB] FAIL loop_reset_run: minx=%h prog=%b expected 12/1", minx, progress_ucode);
        else n_pass++;
        advance();
    endtask

    task automatic test_fetch();
`ifdef UCODE_SEQ_IRQ_EN
        logic [47:0] w;
        drive_w(mkw(S_GOTO, 8'h50));
        advance();
        w = mkw(S_LOOP, 8'($urandom));
        for (int i = 0; i < 3; i++) begin
            drive(w, 5'd0, 1'b0, 5'd2, 1'b0, 1'b1);
            advance();
            n_checks++;
            if (irq_taken !== 1'b0) $display("[TB] FAIL irq_deferred: irq_taken=%b expected 0", irq_taken);
            else n_pass++;
        end
        drive(mkw(S_FETCH, 8'h33), 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        n_checks++;
        if (minx !== 8'hE0) $display("[TB] FAIL irq_minx: got %h expected e0", minx);
        else n_pass++;
        advance();
        n_checks++;
        if (irq_taken !== 1'b1 || upc !== 8'hE0)
            $display("[TB] FAIL irq_taken: irq_taken=%b upc=%h expected 1/e0", irq_taken, upc);
        else n_pass++;
        drive_w(mkw(S_GOTO, 8'h20));
        advance();
        n_checks++;
        if (irq_taken !== 1'b0) $display("[TB] FAIL irq_pulse: irq_taken=%b expected 0", irq_taken);
        else n_pass++;
`else
        drive(mkw(S_FETCH, 8'h33), 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        n_checks++;
        if (minx !== 8'h33 || progress_ucode !== 1'b1)
            $display("[TB] FAIL fetch_goto: minx=%h prog=%b expected 33/1", minx, progress_ucode);
        else n_pass++;
        advance();
        n_checks++;
        if (upc !== 8'h33) $display("[TB] FAIL fetch_upc: got %h expected 33", upc);
        else n_pass++;
`endif
    endtask

    task automatic test_trap();
        logic [2:0] st;
        for (int k = 0; k < 2; k++) begin
            st = 3'(6 + k);
            drive_w(mkw(st, 8'($urandom)));
            n_checks++;
            if (minx !== 8'hF0 || progress_ucode !== 1'b1)
                $display("[TB] FAIL trap_minx: styp=%0d minx=%h prog=%b expected f0/1", st, minx, progress_ucode);
            else n_pass++;
            advance();
            n_checks++;
            if (seq_trap !== 1'b1 || upc !== 8'hF0)
                $display("[TB] FAIL trap_pulse: trap=%b upc=%h expected 1/f0", seq_trap, upc);
            else n_pass++;
            drive_w(mkw(S_GOTO, 8'h05));
            advance();
            n_checks++;
            if (seq_trap !== 1'b0) $display("[TB] FAIL trap_clear: trap=%b expected 0", seq_trap);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [47:0] w;
        logic        last_prog;
        last_prog = 1'b1;
        w = '0;
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            // The ROM holds its word while the sequencer stalls.
            if (last_prog) w = mkw(3'($urandom), 8'($urandom));
            drive(w, 5'($urandom), 1'($urandom), 5'($urandom_range(0, 4)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
            n_checks++;
            if (progress_ucode !== exp_prog || (exp_mv && minx !== exp_minx))
                $display("[TB] FAIL rand_next: cycle %0d minx=%h prog=%b expected %h/%b", i, minx, progress_ucode, exp_minx, exp_prog);
            else n_pass++;
            last_prog = exp_prog || !rst_n;
            advance();
            n_checks++;
            if (upc !== m_upc || seq_trap !== m_trap || mem_timeout !== m_timeout)
                $display("[TB] FAIL rand_state: cycle %0d upc=%h trap=%b timeout=%b expected %h/%b/%b",
                         i, upc, seq_trap, mem_timeout, m_upc, m_trap, m_timeout);
            else n_pass++;
`ifdef UCODE_SEQ_IRQ_EN
            n_checks++;
            if (irq_taken !== m_irq)
                $display("[TB] FAIL rand_irq: cycle %0d irq_taken=%b expected %b", i, irq_taken, m_irq);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        d        = '0;
        opcode   = '0;
        cond     = 1'b0;
        shamt    = '0;
        mem_ack  = 1'b0;
        irq_s    = 1'b0;
        test_reset();
        test_dispatch_cond();
        test_waitmem();
        test_timeout();
        test_loop();
        test_fetch();
        test_trap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
